// File: rtl/bus_timer_bank_if.sv
// Processor-side address, write strobe and per-channel interrupt handshake for bus_timer_bank.
// The shared data bus is a tristate net and stays a plain inout port on the design.
interface bus_timer_bank_if #(
  parameter int N_CH = 2
) ();
  logic [7:0]      addr;
  logic            we;
  logic [N_CH-1:0] interrupt_raise;
  logic [N_CH-1:0] interrupt_ack;

  modport master (output addr, we, interrupt_ack, input interrupt_raise);
  modport slave  (input addr, we, interrupt_ack, output interrupt_raise);
endinterface

// File: rtl/bus_timer_bank.sv
// Multi-channel bus timer: shared prescaler, per-channel 16-bit period, one-shot/periodic mode
// and a level interrupt per channel with acknowledge from the processor.
module bus_timer_bank #(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         N_CH       = 2,
  parameter int         PRESCALE   = 100000,
  parameter int         PRESCALE_W = 17
) (
  input  logic            clk,
  input  logic            reset,
  inout  wire  [7:0]      bus_data,
  bus_timer_bank_if.slave bus
);

  localparam logic [8:0]            WIN_END  = {1'b0, BASE_ADDR} + 9'(4 * N_CH);
  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic                  hit;
  logic                  wr;
  logic [3:0]            offset;
  logic [1:0]            ch_sel;
  logic [1:0]            reg_sel;
  logic                  tick;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  oe;
  logic [7:0]            rdata;
  logic [7:0]            rd_mux;

  logic [3:0]  en_v;
  logic [3:0]  irq_en_v;
  logic [3:0]  one_shot_v;
  logic [3:0]  pending_v;
  logic [15:0] period_v [4];

  // 9-bit compare so a window ending at 8'hFF never wraps back to 8'h00
  assign hit     = (bus.addr >= BASE_ADDR) && ({1'b0, bus.addr} < WIN_END);
  assign wr      = hit && bus.we;
  assign offset  = 4'(bus.addr - BASE_ADDR);
  assign ch_sel  = offset[3:2];
  assign reg_sel = offset[1:0];

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRESCALE_W'(1);
  end

  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < N_CH) begin : g_act
      logic        en_q, irq_en_q, one_shot_q, pending_q;
      logic [15:0] period_q, count_q;
      logic [7:0]  shadow_q;
      logic        sel, ctrl_wr, lo_wr, hi_wr, evt;

      assign sel     = wr && (ch_sel == 2'(c));
      assign ctrl_wr = sel && (reg_sel == 2'd0);
      assign lo_wr   = sel && (reg_sel == 2'd1);
      assign hi_wr   = sel && (reg_sel == 2'd2);
      // a period commit on the tick edge restarts the count instead of firing
      assign evt     = tick && en_q && (period_q != 16'd0) && !hi_wr &&
                       (count_q == period_q - 16'd1);

      always_ff @(posedge clk) begin
        if (!reset) begin
          en_q       <= 1'b0;
          irq_en_q   <= 1'b0;
          one_shot_q <= 1'b0;
          pending_q  <= 1'b0;
          period_q   <= '0;
          count_q    <= '0;
          shadow_q   <= '0;
        end else begin
          if (lo_wr) shadow_q <= bus_data;
          if (hi_wr) period_q <= {bus_data, shadow_q};
          if (ctrl_wr) begin
            en_q       <= bus_data[0];
            irq_en_q   <= bus_data[1];
            one_shot_q <= bus_data[2];
            count_q    <= '0;
          end else begin
            if (evt && one_shot_q) en_q <= 1'b0;
            if (hi_wr)
              count_q <= '0;
            else if (tick && en_q && (period_q != 16'd0))
              count_q <= evt ? 16'd0 : count_q + 16'd1;
          end
          // an event beats a simultaneous acknowledge so no interrupt is lost
          if (evt && irq_en_q)             pending_q <= 1'b1;
          else if (bus.interrupt_ack[c])   pending_q <= 1'b0;
        end
      end

      assign en_v[c]       = en_q;
      assign irq_en_v[c]   = irq_en_q;
      assign one_shot_v[c] = one_shot_q;
      assign pending_v[c]  = pending_q;
      assign period_v[c]   = period_q;
    end else begin : g_tie
      assign en_v[c]       = 1'b0;
      assign irq_en_v[c]   = 1'b0;
      assign one_shot_v[c] = 1'b0;
      assign pending_v[c]  = 1'b0;
      assign period_v[c]   = 16'd0;
    end
  end

  assign bus.interrupt_raise = pending_v[N_CH-1:0];

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      2'd0:    rd_mux = {5'b0, one_shot_v[ch_sel], irq_en_v[ch_sel], en_v[ch_sel]};
      2'd1:    rd_mux = period_v[ch_sel][7:0];
      2'd2:    rd_mux = period_v[ch_sel][15:8];
      default: rd_mux = {6'b0, en_v[ch_sel], pending_v[ch_sel]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      oe    <= 1'b0;
      rdata <= 8'h00;
    end else begin
      oe    <= hit && !bus.we;
      rdata <= rd_mux;
    end
  end

  // release the bus immediately if the processor starts a write during the read slot
  assign bus_data = (oe && !bus.we) ? rdata : 8'hzz;

endmodule

// File: tb/tb_bus_timer_bank.sv
// Self-checking bench for bus_timer_bank: register vector table, hand-written timing sequences
// and randomized bus traffic compared against a cycle-level behavioural model.
module tb_bus_timer_bank;
  localparam int PS   = 4;
  localparam int NC   = 2;
  localparam int BASE = 8'hF0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tb_oe = 1'b0;
  logic [7:0] tb_dout = 8'h00;
  wire  [7:0] bus_data;

  bus_timer_bank_if #(.N_CH(NC)) bus_i ();

  bus_timer_bank #(.BASE_ADDR(8'hF0), .N_CH(NC), .PRESCALE(PS), .PRESCALE_W(2)) dut (
    .clk(clk), .reset(reset), .bus_data(bus_data), .bus(bus_i)
  );

  assign bus_data = tb_oe ? tb_dout : 8'hzz;
  // an undriven bus reads 8'hFF
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus_data[i]);
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] obs_data;
  logic [1:0] obs_raise;
  logic [7:0] exp_data;
  logic [1:0] exp_raise;

  // behavioural model state
  int m_pre;
  bit m_en[NC], m_ie[NC], m_os[NC], m_pd[NC];
  int m_per[NC], m_cnt[NC], m_sh[NC];
  bit m_oe;
  int m_rd;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int reg_val(input int c, input int r);
    case (r)
      0:       return int'(m_en[c]) + 2 * int'(m_ie[c]) + 4 * int'(m_os[c]);
      1:       return m_per[c] % 256;
      2:       return m_per[c] / 256;
      default: return int'(m_pd[c]) + 2 * int'(m_en[c]);
    endcase
  endfunction

  task automatic model_step(input bit r, input int a, input bit w, input int d, input int k);
    bit tick, hit, wsel, fire;
    int c, rr;
    if (!r) begin
      m_pre = 0; m_oe = 0; m_rd = 0;
      for (int i = 0; i < NC; i++) begin
        m_en[i] = 0; m_ie[i] = 0; m_os[i] = 0; m_pd[i] = 0;
        m_per[i] = 0; m_cnt[i] = 0; m_sh[i] = 0;
      end
      return;
    end
    tick = (m_pre == PS - 1);
    hit  = (a >= BASE) && (a < BASE + 4 * NC);
    c    = (a - BASE) / 4;
    rr   = (a - BASE) % 4;
    m_oe = hit && !w;
    if (m_oe) m_rd = reg_val(c, rr);
    for (int ch = 0; ch < NC; ch++) begin
      wsel = hit && w && (c == ch);
      fire = tick && m_en[ch] && (m_per[ch] != 0) && !(wsel && rr == 2) &&
             (m_cnt[ch] + 1 == m_per[ch]);
      if (fire && m_ie[ch]) m_pd[ch] = 1;
      else if (((k >> ch) & 1) != 0) m_pd[ch] = 0;
      if (wsel && rr == 0) begin
        m_en[ch] = d[0]; m_ie[ch] = d[1]; m_os[ch] = d[2]; m_cnt[ch] = 0;
      end else begin
        if (wsel && rr == 2) begin
          m_per[ch] = d * 256 + m_sh[ch];
          m_cnt[ch] = 0;
        end else if (tick && m_en[ch] && m_per[ch] != 0) begin
          m_cnt[ch] = (m_cnt[ch] + 1) % m_per[ch];
        end
        if (fire && m_os[ch]) m_en[ch] = 0;
      end
      if (wsel && rr == 1) m_sh[ch] = d;
    end
    m_pre = (m_pre + 1) % PS;
  endtask

  // one bus cycle: drive, let the edge happen, sample mid-cycle and compare with the model
  task automatic cycle(input bit r, input logic [7:0] a, input bit w, input logic [7:0] d,
                       input logic [1:0] k);
    reset = r; bus_i.addr = a; bus_i.we = w; tb_oe = w; tb_dout = d; bus_i.interrupt_ack = k;
    model_step(r, int'(a), w, int'(d), int'(k));
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs_data  = bus_data;
    obs_raise = bus_i.interrupt_raise;
    exp_raise = {m_pd[1], m_pd[0]};
    exp_data  = (m_oe && !w) ? m_rd[7:0] : 8'hFF;
    chk("model_raise", int'(obs_raise), int'(exp_raise));
    if (!w) chk("model_data", int'(obs_data), int'(exp_data));
  endtask

  task automatic idle();                         cycle(1, 8'h00, 0, 8'h00, 2'b00); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d); cycle(1, a, 1, d, 2'b00); endtask
  task automatic rd(input logic [7:0] a);        cycle(1, a, 0, 8'h00, 2'b00); endtask
  task automatic ack(input logic [1:0] k);       cycle(1, 8'h00, 0, 8'h00, k); endtask
  task automatic do_reset();
    cycle(0, 8'h00, 0, 8'h00, 2'b00);
    cycle(0, 8'h00, 0, 8'h00, 2'b00);
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] addr;
    bit         we;
    logic [7:0] data;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int t1, t2, n, highs;
    bit got;
    logic r;
    logic [7:0] a, d;
    bit w;
    logic [1:0] k;

    bus_i.addr = 8'h00; bus_i.we = 1'b0; bus_i.interrupt_ack = 2'b00;

    tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 8'hFF});
    tbl.push_back('{0, 8'h00, 0, 8'h00, 1, 8'hFF});
    for (int i = 0; i < 8; i++) tbl.push_back('{1, 8'(BASE + i), 0, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 8'hF8, 0, 8'h00, 1, 8'hFF});
    tbl.push_back('{1, 8'hEF, 0, 8'h00, 1, 8'hFF});
    tbl.push_back('{1, 8'h00, 0, 8'h00, 1, 8'hFF});
    tbl.push_back('{1, 8'hF2, 1, 8'hAB, 0, 8'h00});
    tbl.push_back('{1, 8'hF2, 0, 8'h00, 1, 8'hAB});
    tbl.push_back('{1, 8'h00, 0, 8'h00, 1, 8'hFF});
    tbl.push_back('{1, 8'hF1, 1, 8'h34, 0, 8'h00});
    tbl.push_back('{1, 8'hF1, 0, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 8'hF2, 1, 8'h12, 0, 8'h00});
    tbl.push_back('{1, 8'hF1, 0, 8'h00, 1, 8'h34});
    tbl.push_back('{1, 8'hF2, 0, 8'h00, 1, 8'h12});
    tbl.push_back('{1, 8'hF0, 1, 8'h06, 0, 8'h00});
    tbl.push_back('{1, 8'hF0, 0, 8'h00, 1, 8'h06});
    tbl.push_back('{1, 8'hF3, 0, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 8'hF3, 1, 8'hFF, 0, 8'h00});
    tbl.push_back('{1, 8'hF3, 0, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 8'hF0, 1, 8'h5A, 0, 8'h00});
    tbl.push_back('{1, 8'h00, 0, 8'h00, 1, 8'hFF});
    tbl.push_back('{1, 8'hF0, 0, 8'h00, 1, 8'h02});
    tbl.push_back('{1, 8'hF5, 1, 8'h77, 0, 8'h00});
    tbl.push_back('{1, 8'hF6, 1, 8'h01, 0, 8'h00});
    tbl.push_back('{1, 8'hF5, 0, 8'h00, 1, 8'h77});
    tbl.push_back('{1, 8'hF6, 0, 8'h00, 1, 8'h01});
    tbl.push_back('{1, 8'hF4, 0, 8'h00, 1, 8'h00});

    @(negedge clk);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].addr, tbl[i].we, tbl[i].data, 2'b00);
      chk("tbl_raise", int'(obs_raise), 0);
      if (tbl[i].chk) chk($sformatf("tbl_data_%0d", i), int'(obs_data), int'(tbl[i].exp));
    end

    // periodic channel 0, period 3 ticks
    do_reset();
    wr(8'hF1, 8'h03); wr(8'hF2, 8'h00); wr(8'hF0, 8'h03);
    got = 0; n = 0;
    while (!got && n < 40) begin idle(); n++; if (obs_raise[0]) got = 1; end
    chk("p_rise_seen", int'(got), 1);
    chk("p_rise_window", int'(n >= 8 && n <= 16), 1);
    t1 = cyc;
    idle(); idle();
    chk("p_held", int'(obs_raise[0]), 1);
    ack(2'b01);
    chk("p_ack_drop", int'(obs_raise[0]), 0);
    got = 0; n = 0;
    while (!got && n < 40) begin idle(); n++; if (obs_raise[0]) got = 1; end
    chk("p_rerise_seen", int'(got), 1);
    t2 = cyc;
    chk("p_interval", t2 - t1, 12);

    // acknowledge landing on the very edge of the next event
    ack(2'b01);
    chk("c_pre_ack", int'(obs_raise[0]), 0);
    while (cyc < t2 + 11) idle();
    ack(2'b01);
    chk("c_event_wins", int'(obs_raise[0]), 1);
    ack(2'b01);
    chk("c_next_ack", int'(obs_raise[0]), 0);

    // one-shot channel 1, period 2 ticks
    wr(8'hF0, 8'h00);
    wr(8'hF5, 8'h02); wr(8'hF6, 8'h00); wr(8'hF4, 8'h07);
    got = 0; n = 0;
    while (!got && n < 30) begin idle(); n++; if (obs_raise[1]) got = 1; end
    chk("o_rise_seen", int'(got), 1);
    chk("o_rise_window", int'(n >= 4 && n <= 12), 1);
    rd(8'hF7);
    chk("o_status", int'(obs_data), 8'h01);
    rd(8'hF4);
    chk("o_ctrl", int'(obs_data), 8'h06);
    ack(2'b10);
    chk("o_ack_drop", int'(obs_raise[1]), 0);
    highs = 0;
    for (int i = 0; i < 100; i++) begin idle(); if (obs_raise != 2'b00) highs++; end
    chk("o_quiet", highs, 0);

    // zero period never fires; reset mid-count
    do_reset();
    wr(8'hF1, 8'h00); wr(8'hF2, 8'h00); wr(8'hF0, 8'h03);
    highs = 0;
    for (int i = 0; i < 200; i++) begin idle(); if (obs_raise != 2'b00) highs++; end
    chk("z_no_raise", highs, 0);
    wr(8'hF1, 8'h01); wr(8'hF2, 8'h00);
    wr(8'hF5, 8'h01); wr(8'hF6, 8'h00); wr(8'hF4, 8'h03);
    for (int i = 0; i < 6; i++) idle();
    chk("z_active", int'(obs_raise != 2'b00), 1);
    rd(8'hF0);
    cycle(0, 8'h00, 0, 8'h00, 2'b00);
    chk("z_rst_raise", int'(obs_raise), 0);
    chk("z_rst_bus", int'(obs_data), 8'hFF);
    rd(8'hF0); chk("z_ctrl0", int'(obs_data), 8'h00);
    rd(8'hF1); chk("z_per0", int'(obs_data), 8'h00);
    rd(8'hF7); chk("z_stat1", int'(obs_data), 8'h00);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 9))
        0:       a = 8'hEF;
        1:       a = 8'hF8;
        default: a = 8'(BASE + $urandom_range(0, 7));
      endcase
      w = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      k = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cycle(r, a, w, d, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
